// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM states, parity helper and default line settings.
package uart_pkg;
  localparam int CLK_FREQ_DEF = 100000000;
  localparam int BAUD_DEF = 1000000;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} rx_state_t;
  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop rx synchroniser (idles high) with falling-edge pulse.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);
  logic q1, q2, q3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q1, q2, q3} <= 3'b111;
    else {q1, q2, q3} <= {rx, q1, q2};
  assign rx_s = q2;
  assign fall = q3 & ~q2;
endmodule

// File: rtl/uart_inst_rx.sv
// uart_inst_rx: UART instruction byte receiver with valid/ready output.
// Define UART_RX_PARITY_EN for 8E1 frames with par_err; default is 8N1.
module uart_inst_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int BAUD = BAUD_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] inst_wd,
  output logic       inst_vld,
  input  logic       inst_rdy,
  output logic       busy,
  output logic       frm_err,
  output logic       par_err,
  output logic       overrun
);
  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int HALF = BIT_CYCLES / 2;
  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] MID = CW'(HALF - 1);
  logic rx_s, fall;
  rx_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
`ifdef UART_RX_PARITY_EN
  logic bad;
`endif
  uart_rx_sync u_sync (.clk(clk), .rst_n(rst_n), .rx(rx), .rx_s(rx_s), .fall(fall));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
`ifdef UART_RX_PARITY_EN
      bad <= 1'b0;
`endif
      inst_wd <= 8'h00;
      inst_vld <= 1'b0;
      busy <= 1'b0;
      frm_err <= 1'b0;
      par_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      frm_err <= 1'b0;
      par_err <= 1'b0;
      overrun <= 1'b0;
      if (inst_vld && inst_rdy) inst_vld <= 1'b0;
      cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (fall) begin
            state <= START;
            busy <= 1'b1;
          end
        end
        START: if (cnt == MID) begin
          cnt <= '0;
          idx <= '0;
`ifdef UART_RX_PARITY_EN
          bad <= 1'b0;
`endif
          state <= rx_s ? IDLE : DATA;
          busy <= ~rx_s;
        end
        DATA: if (cnt == LAST) begin
          cnt <= '0;
          sh <= {rx_s, sh[7:1]};
          idx <= idx + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (idx == 3'd7) state <= PARITY;
`else
          if (idx == 3'd7) state <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (cnt == LAST) begin
          cnt <= '0;
          bad <= rx_s != even_par(sh);
          state <= STOP;
        end
`endif
        STOP: if (cnt == LAST) begin
          if (!rx_s) begin
            frm_err <= 1'b1;
            state <= WAIT_IDLE;
          end else begin
            state <= IDLE;
            busy <= 1'b0;
`ifdef UART_RX_PARITY_EN
            if (bad) par_err <= 1'b1;
            else
`endif
            if (!inst_vld || inst_rdy) begin
              inst_wd <= sh;
              inst_vld <= 1'b1;
            end else overrun <= 1'b1;
          end
        end
        WAIT_IDLE: if (rx_s) begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_inst_rx.sv
// tb_uart_inst_rx: randomized frame stimulus checked against a byte-level reference.
module tb_uart_inst_rx;
  localparam int BC = 100;
  localparam int HALF = 50;
`ifdef UART_RX_PARITY_EN
  localparam int FLEN = 11;
`else
  localparam int FLEN = 10;
`endif
  localparam int LAT = 3 + HALF + (FLEN - 1) * BC;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, inst_rdy = 1'b0;
  logic [7:0] inst_wd;
  logic inst_vld, busy, frm_err, par_err, overrun;
  int pass = 0, total = 0;
  int cyc = 0, n_frm = 0, n_par = 0, n_ovr = 0, n_vld = 0, rise_cyc = 0;
  logic vld_d = 1'b0;
  logic [7:0] got[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  uart_inst_rx #(.CLK_FREQ(100000000), .BAUD(1000000)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .inst_wd(inst_wd), .inst_vld(inst_vld),
    .inst_rdy(inst_rdy), .busy(busy), .frm_err(frm_err), .par_err(par_err), .overrun(overrun)
  );
  always @(negedge clk)
    if (rst_n) begin
      if (inst_vld && inst_rdy) got.push_back(inst_wd);
      if (frm_err) n_frm <= n_frm + 1;
      if (par_err) n_par <= n_par + 1;
      if (overrun) n_ovr <= n_ovr + 1;
      if (inst_vld) n_vld <= n_vld + 1;
      if (inst_vld && !vld_d) rise_cyc <= cyc;
      vld_d <= inst_vld;
    end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic send_bits(input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      tick(BC);
    end
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
    send_bits({1'b0, stop, ^d, d, 1'b0}, FLEN);
`else
    send_bits({2'b00, stop, d, 1'b0}, FLEN);
`endif
  endtask
  task automatic test_reset;
    tick(5);
    total++; if ({inst_wd, inst_vld, busy, frm_err, par_err, overrun} !== 13'h0) $display("FAIL reset_in got=%h exp=0", {inst_wd, inst_vld, busy, frm_err, par_err, overrun}); else pass++;
    rst_n = 1'b1;
    tick(5);
    total++; if ({inst_wd, inst_vld, busy, frm_err, par_err, overrun} !== 13'h0) $display("FAIL reset_out got=%h exp=0", {inst_wd, inst_vld, busy, frm_err, par_err, overrun}); else pass++;
  endtask
  task automatic test_basic;
    int g0, v0, e0, p;
    inst_rdy = 1'b1;
    g0 = got.size(); v0 = n_vld; e0 = n_frm + n_par + n_ovr; p = cyc;
    send_frame(8'h34, 1'b1);
    tick(20);
    total++; if (got.size() - g0 !== 1) $display("FAIL basic_count got=%0d exp=1", got.size() - g0); else pass++;
    total++; if (got[g0] !== 8'h34) $display("FAIL basic_data got=%h exp=34", got[g0]); else pass++;
    total++; if (n_vld - v0 !== 1) $display("FAIL basic_vld_cycles got=%0d exp=1", n_vld - v0); else pass++;
    total++; if (rise_cyc - p !== LAT) $display("FAIL basic_latency got=%0d exp=%0d", rise_cyc - p, LAT); else pass++;
    total++; if (n_frm + n_par + n_ovr - e0 !== 0) $display("FAIL basic_errs got=%0d exp=0", n_frm + n_par + n_ovr - e0); else pass++;
    total++; if (busy !== 1'b0) $display("FAIL basic_busy got=%b exp=0", busy); else pass++;
  endtask
  task automatic test_back_to_back;
    logic [7:0] exp[$];
    int g0, v0, e0;
    inst_rdy = 1'b1;
    g0 = got.size(); v0 = n_vld; e0 = n_frm + n_par + n_ovr;
    for (int i = 0; i < 6; i++) begin
      exp.push_back(8'($urandom));
      send_frame(exp[i], 1'b1);
    end
    tick(20);
    total++; if (got.size() - g0 !== 6) $display("FAIL b2b_count got=%0d exp=6", got.size() - g0); else pass++;
    for (int i = 0; i < 6; i++) begin
      total++; if (got[g0 + i] !== exp[i]) $display("FAIL b2b_data%0d got=%h exp=%h", i, got[g0 + i], exp[i]); else pass++;
    end
    total++; if (n_vld - v0 !== 6) $display("FAIL b2b_vld_cycles got=%0d exp=6", n_vld - v0); else pass++;
    total++; if (n_frm + n_par + n_ovr - e0 !== 0) $display("FAIL b2b_errs got=%0d exp=0", n_frm + n_par + n_ovr - e0); else pass++;
  endtask
  task automatic test_glitch;
    int g0, f0;
    g0 = got.size(); f0 = n_frm;
    rx = 1'b0; tick(30); rx = 1'b1; tick(200);
    total++; if (got.size() - g0 !== 0) $display("FAIL glitch_vld got=%0d exp=0", got.size() - g0); else pass++;
    total++; if (n_frm - f0 !== 0) $display("FAIL glitch_frm got=%0d exp=0", n_frm - f0); else pass++;
    total++; if (busy !== 1'b0) $display("FAIL glitch_busy got=%b exp=0", busy); else pass++;
    send_frame(8'hA5, 1'b1);
    tick(20);
    total++; if (got.size() - g0 !== 1 || got[g0] !== 8'hA5) $display("FAIL glitch_next got=%h n=%0d exp=a5", got[g0], got.size() - g0); else pass++;
  endtask
  task automatic test_break;
    int g0, f0;
    g0 = got.size(); f0 = n_frm;
    send_frame(8'h0F, 1'b0);
    tick(300);
    total++; if (busy !== 1'b1) $display("FAIL break_busy_held got=%b exp=1", busy); else pass++;
    rx = 1'b1; tick(20);
    total++; if (n_frm - f0 !== 1) $display("FAIL break_frm got=%0d exp=1", n_frm - f0); else pass++;
    total++; if (got.size() - g0 !== 0) $display("FAIL break_vld got=%0d exp=0", got.size() - g0); else pass++;
    total++; if (busy !== 1'b0) $display("FAIL break_busy got=%b exp=0", busy); else pass++;
    send_frame(8'hC0, 1'b1);
    tick(20);
    total++; if (got.size() - g0 !== 1 || got[g0] !== 8'hC0) $display("FAIL break_next got=%h n=%0d exp=c0", got[g0], got.size() - g0); else pass++;
  endtask
  task automatic test_overrun;
    int g0, o0;
    inst_rdy = 1'b0;
    g0 = got.size(); o0 = n_ovr;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(5);
    total++; if (inst_vld !== 1'b1) $display("FAIL ovr_vld got=%b exp=1", inst_vld); else pass++;
    total++; if (inst_wd !== 8'h11) $display("FAIL ovr_wd got=%h exp=11", inst_wd); else pass++;
    total++; if (n_ovr - o0 !== 1) $display("FAIL ovr_pulse got=%0d exp=1", n_ovr - o0); else pass++;
    inst_rdy = 1'b1;
    tick(1);
    total++; if (inst_vld !== 1'b0) $display("FAIL ovr_drop got=%b exp=0", inst_vld); else pass++;
    total++; if (got.size() - g0 !== 1 || got[g0] !== 8'h11) $display("FAIL ovr_accept got=%h n=%0d exp=11", got[g0], got.size() - g0); else pass++;
  endtask
  task automatic test_mid_reset;
    int g0;
    inst_rdy = 1'b1;
    g0 = got.size();
    rx = 1'b0; tick(BC);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1; tick(BC);
    end
    tick(HALF);
    total++; if (busy !== 1'b1) $display("FAIL mid_busy got=%b exp=1", busy); else pass++;
    rst_n = 1'b0;
    #1;
    total++; if ({inst_wd, inst_vld, busy, frm_err, par_err, overrun} !== 13'h0) $display("FAIL mid_reset got=%h exp=0", {inst_wd, inst_vld, busy, frm_err, par_err, overrun}); else pass++;
    rx = 1'b1; tick(3);
    rst_n = 1'b1; tick(2 * BC);
    total++; if (got.size() - g0 !== 0 || busy !== 1'b0) $display("FAIL mid_idle got=%0d busy=%b exp=0/0", got.size() - g0, busy); else pass++;
    send_frame(8'h5A, 1'b1);
    tick(20);
    total++; if (got.size() - g0 !== 1 || got[g0] !== 8'h5A) $display("FAIL mid_next got=%h n=%0d exp=5a", got[g0], got.size() - g0); else pass++;
  endtask
`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int g0, p0;
    inst_rdy = 1'b1;
    g0 = got.size(); p0 = n_par;
    send_bits({1'b0, 1'b1, 1'b1, 8'h03, 1'b0}, FLEN);
    tick(20);
    total++; if (n_par - p0 !== 1) $display("FAIL par_bad_pulse got=%0d exp=1", n_par - p0); else pass++;
    total++; if (got.size() - g0 !== 0) $display("FAIL par_bad_vld got=%0d exp=0", got.size() - g0); else pass++;
    send_bits({1'b0, 1'b1, 1'b0, 8'h03, 1'b0}, FLEN);
    tick(20);
    total++; if (n_par - p0 !== 1) $display("FAIL par_good_pulse got=%0d exp=1", n_par - p0); else pass++;
    total++; if (got.size() - g0 !== 1 || got[g0] !== 8'h03) $display("FAIL par_good_data got=%h n=%0d exp=03", got[g0], got.size() - g0); else pass++;
  endtask
`endif
  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_glitch;
    test_break;
    test_overrun;
    test_mid_reset;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
